gray_ptr_rd_ctrl: RTL and testbench

- Read-side pointer controller for the team's asynchronous FIFO. It sits directly downstream of the write-domain Gray counter.
- It takes the foreign-domain Gray write pointer, synchronizes it into the local clock, and converts it to binary.
- It runs the local read pointer in both binary and Gray form, and produces the RAM read address, empty/almost-empty flags, fill level and the Gray read pointer returned to the write side.

---
 rtl/gray_ptr_rd_ctrl.sv | 78 +++++++
 tb/tb_gray_ptr_rd_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rd_ctrl.sv
// Read-side pointer controller for the async FIFO: write-pointer synchronizer, read pointers, flags and level.
// Optional sticky underflow flag is enabled with `define GRAY_PTR_RD_UNDERFLOW_EN.
module gray_ptr_rd_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1,
    localparam int P          = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [P-1:0]          wr_ptr_gry,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [P-1:0]          rd_ptr_gry,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [P-1:0]          rd_level,
    output logic                  underflow
);

    logic [SYNC_STAGES-1:0][P-1:0] sync_q;
    logic [P-1:0] wsync_gry;
    logic [P-1:0] wsync_bin;
    logic [P-1:0] rd_ptr_bin;
    logic [P-1:0] rd_bin_next;
    logic [P-1:0] rd_gry_next;
    logic [P-1:0] level_next;
    logic         rd_acc;

    // Plain flop chain; stage 0 is the only one that sees the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gry};
    end

    assign wsync_gry = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wsync_bin = '0;
        for (int i = 0; i < P; i++) wsync_bin[i] = ^(wsync_gry >> i);
    end

    assign rd_acc      = rd_en & ~empty;
    assign rd_bin_next = rd_ptr_bin + {{(P-1){1'b0}}, rd_acc};
    assign rd_gry_next = (rd_bin_next >> 1) ^ rd_bin_next;
    assign level_next  = wsync_bin - rd_bin_next;
    assign rd_addr     = rd_ptr_bin[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_bin   <= '0;
            rd_ptr_gry   <= '0;
            rd_valid     <= 1'b0;
            rd_level     <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            rd_ptr_bin   <= rd_bin_next;
            rd_ptr_gry   <= rd_gry_next;
            rd_valid     <= rd_acc;
            rd_level     <= level_next;
            empty        <= (rd_gry_next == wsync_gry);
            almost_empty <= (level_next <= P'(AE_THRESH));
        end
    end

`ifdef GRAY_PTR_RD_UNDERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              underflow <= 1'b0;
        else if (rd_en && empty) underflow <= 1'b1;
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_rd_ctrl.sv
// Scoreboard bench for gray_ptr_rd_ctrl at ADDR_WIDTH=3, SYNC_STAGES=2, AE_THRESH=1.
module tb_gray_ptr_rd_ctrl;
    localparam int AW = 3;
    localparam int P  = 4;
`ifdef GRAY_PTR_RD_UNDERFLOW_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    localparam logic [3:0] GRAY [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                         4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                         4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                         4'b1010, 4'b1011, 4'b1001, 4'b1000};
    // Levels during the read burst that overlaps writes 13..16.
    localparam logic [3:0] LV_MIX [8] = '{4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [P-1:0]  wr_ptr_gry = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [P-1:0]  rd_ptr_gry;
    logic          empty;
    logic          almost_empty;
    logic [P-1:0]  rd_level;
    logic          underflow;

    gray_ptr_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AE_THRESH(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_ptr_gry(wr_ptr_gry), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ptr_gry(rd_ptr_gry),
        .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [P-1:0]  gry;
        logic          emp;
        logic [P-1:0]  lvl;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [3:0] gry, input logic emp, input logic [3:0] lvl);
        exp_t e;
        e.addr = AW'(addr);
        e.gry  = gry;
        e.emp  = emp;
        e.lvl  = lvl;
        sbq.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_level"}, 32'(rd_level), 32'd0);
        chk({tag, "_gry"}, 32'(rd_ptr_gry), 32'd0);
        chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_uf"}, 32'(underflow), 32'd0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("mon_addr", 32'(rd_addr), 32'(e.addr));
                chk("mon_gry", 32'(rd_ptr_gry), 32'(e.gry));
                chk("mon_empty", 32'(empty), 32'(e.emp));
                chk("mon_level", 32'(rd_level), 32'(e.lvl));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: asynchronous reset mid-clock
        #2 rst_n = 1'b0;
        #1 chk_reset("rst0");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // 2: single write, three-edge latency
        wr_ptr_gry = GRAY[1];
        tick(); chk("lat_e1_empty", 32'(empty), 32'd1);
        tick(); chk("lat_e2_empty", 32'(empty), 32'd1);
                chk("lat_e2_level", 32'(rd_level), 32'd0);
        tick(); chk("lat_e3_empty", 32'(empty), 32'd0);
                chk("lat_e3_level", 32'(rd_level), 32'd1);
                chk("lat_e3_ae", 32'(almost_empty), 32'd1);

        // 3: fill to 8, then drain with a continuous burst
        for (int v = 2; v <= 8; v++) begin
            wr_ptr_gry = GRAY[v];
            tick();
        end
        tick(); tick(); tick();
        chk("full_level", 32'(rd_level), 32'd8);
        chk("full_empty", 32'(empty), 32'd0);
        chk("full_ae", 32'(almost_empty), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            push(i % 8, GRAY[i], i == 8, 4'(8 - i));
            tick();
        end
        rd_en = 1'b0;
        tick();
        chk("drain_valid", 32'(rd_valid), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_gry", 32'(rd_ptr_gry), 32'b1100);
        chk("drain_level", 32'(rd_level), 32'd0);

        // 4: writes 9..12, then reads overlapping writes 13..16 across the wrap
        for (int v = 9; v <= 12; v++) begin
            wr_ptr_gry = GRAY[v];
            tick();
        end
        tick(); tick(); tick();
        chk("wrap_pre_level", 32'(rd_level), 32'd4);
        for (int t = 1; t <= 8; t++) begin
            if (t <= 4) wr_ptr_gry = GRAY[(12 + t) % 16];
            rd_en = 1'b1;
            push(t % 8, GRAY[(8 + t) % 16], t == 8, LV_MIX[t-1]);
            tick();
        end
        rd_en = 1'b0;
        tick();
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_gry", 32'(rd_ptr_gry), 32'b0000);
        chk("wrap_level", 32'(rd_level), 32'd0);

        // 5: reads while empty are ignored
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("uf_gry", 32'(rd_ptr_gry), 32'd0);
            chk("uf_addr", 32'(rd_addr), 32'd0);
            chk("uf_valid", 32'(rd_valid), 32'd0);
            chk("uf_flag", 32'(underflow), 32'(UF_EXP));
        end
        rd_en = 1'b0;
        tick(); tick();
        chk("uf_sticky", 32'(underflow), 32'(UF_EXP));

        // 6: fill to 8, reset during a read burst
        for (int v = 1; v <= 8; v++) begin
            wr_ptr_gry = GRAY[v];
            tick();
        end
        tick(); tick(); tick();
        chk("refill_level", 32'(rd_level), 32'd8);
        chk("refill_empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            // The third read's rd_valid is still in flight when reset hits, so it is never seen.
            if (i <= 2) push(i, GRAY[i], 1'b0, 4'(8 - i));
            tick();
        end
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); chk("resync_e1_empty", 32'(empty), 32'd1);
        tick(); chk("resync_e2_empty", 32'(empty), 32'd1);
        tick(); chk("resync_e3_empty", 32'(empty), 32'd0);
                chk("resync_e3_level", 32'(rd_level), 32'd8);
                chk("resync_e3_ae", 32'(almost_empty), 32'd0);
                chk("resync_uf", 32'(underflow), 32'd0);
        tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
